pipeline_hazard_ctrl: RTL and testbench

- Pipeline control unit for the vector core. Sits beside the instruction decoder in ID.
- Consumes decoded source/destination/branch/memory fields and sequences the front end: RAW-hazard stalls via a destination scoreboard, branch-resolution wait/flush, and data-memory request/ack handshake.
- Drives the PC, IF/ID and ID/EX register enables, plus the pipeline-wide hold.

---
 rtl/pipeline_hazard_ctrl_if.sv | 46 ++++
 rtl/pipeline_hazard_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: ID-stage decode fields in, front-end
// enables out, plus the data-memory request/ack pair.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [REG_AW-1:0] id_src_a;
  logic [REG_AW-1:0] id_src_b;
  logic [REG_AW-1:0] id_rd;
  logic              id_wr_en;
  logic              id_load;
  logic              id_mem_en;
  logic [1:0]        id_br;
  logic              ex_br_resolved;
  logic              ex_br_taken;
  logic              mem_ack;
  logic              pc_we;
  logic              ifid_we;
  logic              idex_bubble;
  logic              pipe_hold;
  logic              flush_ifid;
  logic              mem_req;
  logic [1:0]        ctrl_state;

  modport master (
    output id_valid, id_src_a, id_src_b,
    output id_rd, id_wr_en, id_load,
    output id_mem_en, id_br,
    output ex_br_resolved, ex_br_taken,
    output mem_ack,
    input  pc_we, ifid_we, idex_bubble,
    input  pipe_hold, flush_ifid,
    input  mem_req, ctrl_state
  );

  modport slave (
    input  id_valid, id_src_a, id_src_b,
    input  id_rd, id_wr_en, id_load,
    input  id_mem_en, id_br,
    input  ex_br_resolved, ex_br_taken,
    input  mem_ack,
    output pc_we, ifid_we, idex_bubble,
    output pipe_hold, flush_ifid,
    output mem_req, ctrl_state
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: RAW scoreboard, branch wait/flush, mem wait.
// Optional HDU_FORWARD_EN: only load-use against EX raises a hazard.
module pipeline_hazard_ctrl #(
  parameter int WB_DEPTH = 3,
  parameter int REG_AW   = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pipeline_hazard_ctrl_if.slave hdu
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    BR_WAIT  = 2'b01,
    FLUSH    = 2'b10,
    MEM_WAIT = 2'b11
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WB_DEPTH-1:0]             sb_v;
  logic [WB_DEPTH-1:0][REG_AW-1:0] sb_rd;
`ifdef HDU_FORWARD_EN
  logic [WB_DEPTH-1:0]             sb_ld;
`endif

  logic hit;
  logic issue;
  logic hold;
  logic a_nz;
  logic b_nz;
  logic sb_wr;

  assign a_nz  = |hdu.id_src_a;
  assign b_nz  = |hdu.id_src_b;
  assign hold  = (state == MEM_WAIT) & ~hdu.mem_ack;
  assign issue = hdu.id_valid & ~hit
               & (state == RUN) & ~hold;
  assign sb_wr = issue & hdu.id_wr_en
               & (|hdu.id_rd);

  // hazard detect: any tracked producer matches a nonzero source
  always_comb begin
    hit = 1'b0;
`ifdef HDU_FORWARD_EN
    if (sb_v[0] && sb_ld[0]) begin
      if (a_nz && sb_rd[0] == hdu.id_src_a)
        hit = 1'b1;
      if (b_nz && sb_rd[0] == hdu.id_src_b)
        hit = 1'b1;
    end
`else
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (sb_v[i]) begin
        if (a_nz && sb_rd[i] == hdu.id_src_a)
          hit = 1'b1;
        if (b_nz && sb_rd[i] == hdu.id_src_b)
          hit = 1'b1;
      end
    end
`endif
    hit = hit & hdu.id_valid;
  end

  // destination scoreboard, advances with the pipe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sb_v  <= '0;
      sb_rd <= '0;
`ifdef HDU_FORWARD_EN
      sb_ld <= '0;
`endif
    end else if (!hold) begin
      for (int i = WB_DEPTH - 1; i > 0; i--) begin
        sb_v[i]  <= sb_v[i-1];
        sb_rd[i] <= sb_rd[i-1];
`ifdef HDU_FORWARD_EN
        sb_ld[i] <= sb_ld[i-1];
`endif
      end
      sb_v[0]  <= sb_wr;
      sb_rd[0] <= sb_wr ? hdu.id_rd : '0;
`ifdef HDU_FORWARD_EN
      sb_ld[0] <= sb_wr & hdu.id_load;
`endif
    end
  end

  // next-state selection; branch wins over memory
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN: begin
        if (issue && (|hdu.id_br))
          state_nxt = BR_WAIT;
        else if (issue && hdu.id_mem_en)
          state_nxt = MEM_WAIT;
      end
      BR_WAIT: begin
        if (hdu.ex_br_resolved)
          state_nxt = hdu.ex_br_taken
                    ? FLUSH : RUN;
      end
      FLUSH:    state_nxt = RUN;
      MEM_WAIT: begin
        if (hdu.mem_ack)
          state_nxt = RUN;
      end
      default:  state_nxt = RUN;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= RUN;
    else
      state <= state_nxt;
  end

  // front-end enables, combinational from state and ID
  always_comb begin
    hdu.pc_we       = 1'b1;
    hdu.ifid_we     = 1'b1;
    hdu.idex_bubble = 1'b0;
    hdu.pipe_hold   = 1'b0;
    hdu.flush_ifid  = 1'b0;
    hdu.mem_req     = 1'b0;
    unique case (state)
      RUN: begin
        if (hit) begin
          hdu.pc_we       = 1'b0;
          hdu.ifid_we     = 1'b0;
          hdu.idex_bubble = 1'b1;
        end
      end
      BR_WAIT: begin
        hdu.pc_we       = 1'b0;
        hdu.ifid_we     = 1'b0;
        hdu.idex_bubble = 1'b1;
      end
      FLUSH: begin
        hdu.flush_ifid  = 1'b1;
        hdu.idex_bubble = 1'b1;
      end
      MEM_WAIT: begin
        hdu.pc_we       = 1'b0;
        hdu.ifid_we     = 1'b0;
        hdu.idex_bubble = 1'b1;
        hdu.mem_req     = hold;
        hdu.pipe_hold   = hold;
      end
      default: ;
    endcase
  end

  assign hdu.ctrl_state = state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed stimulus, expected outputs
// queued per cycle and popped at the falling edge.
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic       v;
    logic [4:0] a;
    logic [4:0] b;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic       mem;
    logic [1:0] br;
    logic       res;
    logic       tk;
    logic       ack;
    logic       rst_n;
  } stim_t;

  typedef struct packed {
    logic       pc;
    logic       ifid;
    logic       bub;
    logic       hold;
    logic       fl;
    logic       req;
    logic [1:0] st;
  } exp_t;

  localparam exp_t E_RUN =
    {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
  localparam exp_t E_STALL =
    {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
  localparam exp_t E_BRW =
    {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01};
  localparam exp_t E_FL =
    {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10};
  localparam exp_t E_MW =
    {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11};
  localparam exp_t E_MACK =
    {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11};

`ifdef HDU_FORWARD_EN
  localparam int ALU_STALLS  = 0;
  localparam int LOAD_STALLS = 1;
`else
  localparam int ALU_STALLS  = 3;
  localparam int LOAD_STALLS = 3;
`endif

  logic clk;
  logic reset_n;

  pipeline_hazard_ctrl_if #(.REG_AW(5)) hdu ();

  pipeline_hazard_ctrl #(
    .WB_DEPTH(3),
    .REG_AW  (5)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .hdu    (hdu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_chk;
  int   n_fail;
  int   n_step;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h",
               tag, n_step, obs, exp);
    end
  endtask

  function automatic stim_t nop();
    stim_t s;
    s       = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  function automatic stim_t ins(
    input logic [4:0] a,
    input logic [4:0] b,
    input logic [4:0] rd,
    input logic       wr,
    input logic       ld,
    input logic       mem,
    input logic [1:0] br
  );
    stim_t s;
    s     = nop();
    s.v   = 1'b1;
    s.a   = a;
    s.b   = b;
    s.rd  = rd;
    s.wr  = wr;
    s.ld  = ld;
    s.mem = mem;
    s.br  = br;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    hdu.id_valid       = s.v;
    hdu.id_src_a       = s.a;
    hdu.id_src_b       = s.b;
    hdu.id_rd          = s.rd;
    hdu.id_wr_en       = s.wr;
    hdu.id_load        = s.ld;
    hdu.id_mem_en      = s.mem;
    hdu.id_br          = s.br;
    hdu.ex_br_resolved = s.res;
    hdu.ex_br_taken    = s.tk;
    hdu.mem_ack        = s.ack;
    reset_n            = s.rst_n;
  endtask

  task automatic compare();
    exp_t e;
    e = exp_q.pop_front();
    chk("pc_we",       {7'd0, hdu.pc_we},       {7'd0, e.pc});
    chk("ifid_we",     {7'd0, hdu.ifid_we},     {7'd0, e.ifid});
    chk("idex_bubble", {7'd0, hdu.idex_bubble}, {7'd0, e.bub});
    chk("pipe_hold",   {7'd0, hdu.pipe_hold},   {7'd0, e.hold});
    chk("flush_ifid",  {7'd0, hdu.flush_ifid},  {7'd0, e.fl});
    chk("mem_req",     {7'd0, hdu.mem_req},     {7'd0, e.req});
    chk("ctrl_state",  {6'd0, hdu.ctrl_state},  {6'd0, e.st});
  endtask

  task automatic step(input stim_t s, input exp_t e);
    apply(s);
    exp_q.push_back(e);
    @(negedge clk);
    compare();
    n_step++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(nop(), E_RUN);
  endtask

  initial begin
    stim_t s;
    n_chk  = 0;
    n_fail = 0;
    n_step = 0;

    s       = nop();
    s.rst_n = 1'b0;
    step(s, E_RUN);
    step(s, E_RUN);
    idle(1);

    // RAW on an ALU producer
    step(ins(5'd1, 5'd2, 5'd5, 1, 0, 0, 2'b00), E_RUN);
    for (int i = 0; i < ALU_STALLS; i++)
      step(ins(5'd5, 5'd3, 5'd6, 0, 0, 0, 2'b00), E_STALL);
    step(ins(5'd5, 5'd3, 5'd6, 0, 0, 0, 2'b00), E_RUN);
    idle(3);

    // register 0 never hazards
    step(ins(5'd1, 5'd2, 5'd0, 1, 0, 0, 2'b00), E_RUN);
    step(ins(5'd0, 5'd0, 5'd4, 0, 0, 0, 2'b00), E_RUN);
    idle(3);

    // load-use on source B
    step(ins(5'd1, 5'd2, 5'd7, 1, 1, 0, 2'b00), E_RUN);
    for (int i = 0; i < LOAD_STALLS; i++)
      step(ins(5'd3, 5'd7, 5'd8, 0, 0, 0, 2'b00), E_STALL);
    step(ins(5'd3, 5'd7, 5'd8, 0, 0, 0, 2'b00), E_RUN);
    idle(3);

    // ALU producer into a B-side consumer
    step(ins(5'd1, 5'd2, 5'd7, 1, 0, 0, 2'b00), E_RUN);
    for (int i = 0; i < ALU_STALLS; i++)
      step(ins(5'd3, 5'd7, 5'd8, 0, 0, 0, 2'b00), E_STALL);
    step(ins(5'd3, 5'd7, 5'd8, 0, 0, 0, 2'b00), E_RUN);
    idle(3);

    // branch taken: 01, 01, 10, 00
    step(ins(5'd1, 5'd0, 5'd0, 0, 0, 0, 2'b10), E_RUN);
    step(nop(), E_BRW);
    s     = nop();
    s.res = 1'b1;
    s.tk  = 1'b1;
    step(s, E_BRW);
    step(nop(), E_FL);
    step(nop(), E_RUN);

    // branch not taken: 01 straight back to 00
    step(ins(5'd1, 5'd0, 5'd0, 0, 0, 0, 2'b11), E_RUN);
    step(nop(), E_BRW);
    s     = nop();
    s.res = 1'b1;
    s.tk  = 1'b0;
    step(s, E_BRW);
    step(nop(), E_RUN);

    // stray resolve and stray ack in RUN
    s     = nop();
    s.res = 1'b1;
    s.tk  = 1'b1;
    step(s, E_RUN);
    s     = nop();
    s.ack = 1'b1;
    step(s, E_RUN);
    step(nop(), E_RUN);

    // branch and memory together: branch wins
    step(ins(5'd0, 5'd0, 5'd0, 0, 0, 1, 2'b10), E_RUN);
    step(nop(), E_BRW);
    s     = nop();
    s.res = 1'b1;
    step(s, E_BRW);
    step(nop(), E_RUN);
    idle(3);

    // store with 4 wait cycles; scoreboard frozen
    step(ins(5'd1, 5'd2, 5'd5, 1, 0, 0, 2'b00), E_RUN);
    step(ins(5'd1, 5'd2, 5'd0, 0, 0, 1, 2'b00), E_RUN);
    for (int i = 0; i < 4; i++)
      step(ins(5'd5, 5'd0, 5'd9, 0, 0, 0, 2'b00), E_MW);
    s     = ins(5'd5, 5'd0, 5'd9, 0, 0, 0, 2'b00);
    s.ack = 1'b1;
    step(s, E_MACK);
`ifndef HDU_FORWARD_EN
    step(ins(5'd5, 5'd0, 5'd9, 0, 0, 0, 2'b00), E_STALL);
`endif
    step(ins(5'd5, 5'd0, 5'd9, 0, 0, 0, 2'b00), E_RUN);
    idle(3);

    // ack in the first wait cycle
    step(ins(5'd0, 5'd0, 5'd0, 0, 0, 1, 2'b00), E_RUN);
    s     = nop();
    s.ack = 1'b1;
    step(s, E_MACK);
    step(nop(), E_RUN);
    idle(2);

    // reset while waiting on memory clears everything
    step(ins(5'd1, 5'd2, 5'd9, 1, 0, 0, 2'b00), E_RUN);
    step(ins(5'd0, 5'd0, 5'd0, 0, 0, 1, 2'b00), E_RUN);
    step(nop(), E_MW);
    s       = nop();
    s.rst_n = 1'b0;
    step(s, E_RUN);
    step(ins(5'd9, 5'd9, 5'd0, 0, 0, 0, 2'b00), E_RUN);
    idle(1);

    chk("queue_empty", 8'(exp_q.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
